jtcps_snd_mixn: RTL and testbench



---
 rtl/jtcps_snd_pkg.sv | 42 ++++
 rtl/jtcps_snd_gainramp.sv | 56 +++++
 rtl/jtcps_snd_mixn.sv | 183 ++++++++++++++++++
 tb/tb_jtcps_snd_mixn.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcps_snd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtcps_snd_pkg                                             |
// | Purpose  : Shared definitions for the CPS N-channel sound mixer:     |
// |            4.4 unity gain, FSM encoding, clog2 and clamp limits.     |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package jtcps_snd_pkg;

  // 4.4 unsigned fixed point: 0x10 is a gain of exactly 1.0
  localparam logic [7:0] GAIN_UNITY = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions; clog2_f(1) = 0
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Largest positive value representable in a signed word of width wout
  function automatic longint sat_hi(input int wout);
    return (64'sd1 <<< (wout - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed word of width wout
  function automatic longint sat_lo(input int wout);
    return -(64'sd1 <<< (wout - 1));
  endfunction

endpackage : jtcps_snd_pkg
`default_nettype wire

// File: rtl/jtcps_snd_gainramp.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtcps_snd_gainramp                                        |
// | Purpose  : Bank of per-channel effective gains. When stepped, the    |
// |            addressed gain moves one LSB toward its target, giving    |
// |            click-free enable/mute and gain changes.                  |
// | Ports    : clk, rst    clock / synchronous active-high reset         |
// |            step_i      update the addressed channel this cycle       |
// |            idx_i       channel address                               |
// |            tgt_i       target gain for the addressed channel (4.4)   |
// |            gnext_o     stepped gain of the addressed channel         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module jtcps_snd_gainramp #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_i,
  input  logic [IW-1:0] idx_i,
  input  logic [7:0]    tgt_i,
  output logic [7:0]    gnext_o
);

  logic [7:0] g_q [NCH];
  logic [7:0] w_gcur;
  logic [7:0] g_d;

  // The stepped value is what the MAC multiplies by in the same slot,
  // so a channel ramping up from 0 contributes 1/16 on its first mix.
  always_comb begin
    w_gcur = g_q[idx_i];
    g_d    = w_gcur;
    if (w_gcur < tgt_i) begin
      g_d = w_gcur + 8'd1;
    end else if (w_gcur > tgt_i) begin
      g_d = w_gcur - 8'd1;
    end
  end

  assign gnext_o = g_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        g_q[i] <= '0;
      end
    end else if (step_i) begin
      g_q[idx_i] <= g_d;
    end
  end

endmodule : jtcps_snd_gainramp
`default_nettype wire

// File: rtl/jtcps_snd_mixn.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtcps_snd_mixn                                            |
// | Purpose  : N-channel time-multiplexed audio mixer. One channel is    |
// |            multiply-accumulated per clock with ramped gains, then    |
// |            the sum is scaled by 1/16, saturated and presented with   |
// |            a one-cycle valid strobe and a held clip indicator.       |
// | Ports    : clk, rst    clock / synchronous active-high reset         |
// |            sample_i    strobe: start a new mix (ignored while busy)  |
// |            ch_i        NCH packed signed samples, ch0 in LSBs        |
// |            gain_i      NCH packed 4.4 unsigned target gains          |
// |            en_i        per-channel enable (0 -> target gain 0)       |
// |            mixed_o     saturated mix result                          |
// |            valid_o     one-cycle pulse when mixed_o updates          |
// |            busy_o      high while a mix is in progress               |
// |            peak_o      clip indicator, held PEAKHOLD results         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module jtcps_snd_mixn
  import jtcps_snd_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 16,
  parameter int WOUT     = 16,
  parameter int PEAKHOLD = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_i,
  input  logic [NCH*W-1:0]       ch_i,
  input  logic [NCH*8-1:0]       gain_i,
  input  logic [NCH-1:0]         en_i,
  output logic signed [WOUT-1:0] mixed_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   peak_o
);

  localparam int IW = clog2_f(NCH);
  // Product is W+9 bits; the extra clog2(NCH) bits absorb the sum of all
  // channels, so the accumulator can never wrap.
  localparam int AW = W + 9 + clog2_f(NCH);
  localparam int PW = clog2_f(PEAKHOLD + 1);

  localparam logic signed [AW-1:0] C_LIM_HI = AW'(sat_hi(WOUT));
  localparam logic signed [AW-1:0] C_LIM_LO = AW'(sat_lo(WOUT));

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NCH*W-1:0]       snap_q, snap_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [WOUT-1:0] mixed_q, mixed_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;

  logic signed [W-1:0]    w_samp_arr [NCH];
  logic [7:0]             w_tgt_arr  [NCH];
  logic                   w_step;
  logic [7:0]             w_gnext;
  logic signed [W+8:0]    w_prod;
  logic signed [AW-1:0]   w_prod_ext;
  logic signed [AW-1:0]   w_shr;
  logic signed [WOUT-1:0] w_sat;
  logic                   w_clip;

  // Unpack the snapshot and the per-channel targets. Gain and enable are
  // live: each channel's target is taken at that channel's ACC slot.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_samp_arr[i] = snap_q[i*W +: W];
    assign w_tgt_arr[i]  = en_i[i] ? gain_i[i*8 +: 8] : 8'h00;
  end

  jtcps_snd_gainramp #(
    .NCH (NCH),
    .IW  (IW)
  ) u_gainramp (
    .clk     (clk),
    .rst     (rst),
    .step_i  (w_step),
    .idx_i   (idx_q),
    .tgt_i   (w_tgt_arr[idx_q]),
    .gnext_o (w_gnext)
  );

  // Signed sample times unsigned gain: zero-extend the gain to keep it
  // positive, then widen both so the product is exact in W+9 bits.
  assign w_prod     = (W+9)'(w_samp_arr[idx_q]) * (W+9)'($signed({1'b0, w_gnext}));
  assign w_prod_ext = AW'(w_prod);

  // Drop the 4 fractional gain bits; arithmetic shift rounds toward -inf
  assign w_shr = acc_q >>> 4;

  always_comb begin
    w_clip = 1'b0;
    w_sat  = w_shr[WOUT-1:0];
    if (w_shr > C_LIM_HI) begin
      w_clip = 1'b1;
      w_sat  = C_LIM_HI[WOUT-1:0];
    end else if (w_shr < C_LIM_LO) begin
      w_clip = 1'b1;
      w_sat  = C_LIM_LO[WOUT-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    mixed_d = mixed_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    pcnt_d  = pcnt_q;
    w_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_i) begin
          snap_d  = ch_i;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        w_step = 1'b1;
        acc_d  = acc_q + w_prod_ext;
        if (idx_q == IW'(NCH - 1)) begin
          state_d = ST_SAT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_SAT: begin
        mixed_d = w_sat;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        // A clip reloads the hold; clean results count it down
        if (w_clip) begin
          pcnt_d = PW'(PEAKHOLD);
        end else if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      mixed_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      mixed_q <= mixed_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign mixed_o = mixed_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign peak_o  = (pcnt_q != '0);

endmodule : jtcps_snd_mixn
`default_nettype wire

// File: tb/tb_jtcps_snd_mixn.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_jtcps_snd_mixn                                         |
// | Purpose  : Self-checking bench for jtcps_snd_mixn: reset state,      |
// |            table vectors, gain ramps, saturation/peak hold, strobe   |
// |            overlap, mid-mix reset and randomized mixes vs. a model.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_jtcps_snd_mixn;
  import jtcps_snd_pkg::*;

  localparam int NCH      = 4;
  localparam int W        = 16;
  localparam int WOUT     = 16;
  localparam int PEAKHOLD = 1024;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sample_i = 1'b0;
  logic [NCH*W-1:0]       ch_i = '0;
  logic [NCH*8-1:0]       gain_i = '0;
  logic [NCH-1:0]         en_i = '0;
  logic signed [WOUT-1:0] mixed_o;
  logic                   valid_o;
  logic                   busy_o;
  logic                   peak_o;

  jtcps_snd_mixn #(
    .NCH      (NCH),
    .W        (W),
    .WOUT     (WOUT),
    .PEAKHOLD (PEAKHOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sample_i (sample_i),
    .ch_i     (ch_i),
    .gain_i   (gain_i),
    .en_i     (en_i),
    .mixed_o  (mixed_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .peak_o   (peak_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus currently presented to the mixer
  int             cur_ch [NCH];
  int             cur_g  [NCH];
  logic [NCH-1:0] cur_en;

  // Reference model state: effective gains and remaining peak hold
  int m_geff [NCH];
  int m_pcnt;

  typedef struct {
    int c0, c1, c2, c3;
    int exp_m;
    bit exp_p;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_geff[i] = 0;
    m_pcnt = 0;
  endtask

  // One mix: each gain moves one step toward its target, the weighted
  // sum is divided by 16 (floor) and saturated to 16-bit signed.
  task automatic model_mix(output int em, output bit ep);
    longint acc;
    longint r;
    int     t;
    bit     clip;
    acc = 0;
    for (int i = 0; i < NCH; i++) begin
      t = cur_en[i] ? cur_g[i] : 0;
      if (m_geff[i] < t) m_geff[i] = m_geff[i] + 1;
      else if (m_geff[i] > t) m_geff[i] = m_geff[i] - 1;
      acc = acc + longint'(cur_ch[i]) * longint'(m_geff[i]);
    end
    r = acc / 16;
    if ((acc % 16 != 0) && (acc < 0)) r = r - 1;
    clip = 1'b0;
    if (r > 32767) begin
      r = 32767;
      clip = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      clip = 1'b1;
    end
    if (clip) m_pcnt = PEAKHOLD;
    else if (m_pcnt > 0) m_pcnt = m_pcnt - 1;
    em = int'(r);
    ep = (m_pcnt > 0);
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_i[i*W +: W]   = W'(cur_ch[i]);
      gain_i[i*8 +: 8] = 8'(cur_g[i]);
    end
    en_i = cur_en;
  endtask

  // Full mix: strobe, scramble ch_i while busy, wait for valid with a bound
  task automatic run_mix(output int gm, output bit gp, output int em, output bit ep);
    int lat;
    bit got;
    drive();
    sample_i = 1'b1;
    model_mix(em, ep);
    @(posedge clk); #1;
    sample_i = 1'b0;
    check("busy_start", busy_o, 1);
    for (int i = 0; i < NCH; i++) ch_i[i*W +: W] = W'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      got = valid_o;
    end
    check("latency", got ? lat : -1, NCH + 1);
    check("busy_end", busy_o, 0);
    gm = int'(mixed_o);
    gp = peak_o;
  endtask

  initial begin
    int gm, em, nval, gotm, ex;
    bit gp, ep, gap;

    tbl[0] = '{1000, 0, 0, 0, 1000, 1'b0};
    tbl[1] = '{100, 200, 300, 400, 1000, 1'b0};
    tbl[2] = '{-5, -6, 7, 1, -3, 1'b0};
    tbl[3] = '{32767, 0, 0, 0, 32767, 1'b0};
    tbl[4] = '{-32768, 0, 0, 0, -32768, 1'b0};
    tbl[5] = '{20000, 20000, -5000, -2000, 32767, 1'b1};
    tbl[6] = '{-32768, -32768, 0, 0, -32768, 1'b1};
    tbl[7] = '{30000, 30000, 0, 0, 32767, 1'b1};

    model_reset();
    for (int i = 0; i < NCH; i++) begin
      cur_ch[i] = 0;
      cur_g[i]  = int'(GAIN_UNITY);
    end
    cur_en = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mixed", mixed_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_peak", peak_o, 0);
    rst = 1'b0;

    // Ramp every channel to unity with silent inputs
    for (int k = 0; k < 16; k++) begin
      run_mix(gm, gp, em, ep);
      check("rampin_mixed", gm, em);
    end

    // Table vectors at unity gain, all channels enabled
    for (int k = 0; k < 8; k++) begin
      cur_ch[0] = tbl[k].c0;
      cur_ch[1] = tbl[k].c1;
      cur_ch[2] = tbl[k].c2;
      cur_ch[3] = tbl[k].c3;
      run_mix(gm, gp, em, ep);
      check("tbl_mixed", gm, tbl[k].exp_m);
      check("tbl_peak", gp, tbl[k].exp_p);
    end

    // Peak hold: stays up for PEAKHOLD-1 clean results, drops on the last
    for (int i = 0; i < NCH; i++) cur_ch[i] = 0;
    for (int k = 1; k <= PEAKHOLD; k++) begin
      run_mix(gm, gp, em, ep);
      check("hold_mixed", gm, 0);
      check("hold_peak", gp, (k < PEAKHOLD) ? 1 : 0);
    end

    // Disable ch0 (ch0=16): 15,14,...,0 then 0
    cur_ch[0] = 16;
    cur_en[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      run_mix(gm, gp, em, ep);
      ex = (16 - k > 0) ? 16 - k : 0;
      check("rampdn_mixed", gm, ex);
    end
    // Enable ch0: 1,2,...,16 then 16
    cur_en[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      run_mix(gm, gp, em, ep);
      ex = (k < 16) ? k : 16;
      check("rampup_mixed", gm, ex);
    end

    // Floor rounding of negative values: ch0=-3 at gain 0x08
    cur_ch[0] = -3;
    cur_g[0]  = 8;
    for (int k = 1; k <= 8; k++) begin
      run_mix(gm, gp, em, ep);
      check("neg_model", gm, em);
    end
    check("neg_floor", gm, -2);

    // Second strobe two clocks into a mix: ignored, busy never drops
    cur_ch[0] = 500;
    cur_g[0]  = int'(GAIN_UNITY);
    drive();
    sample_i = 1'b1;
    model_mix(em, ep);
    @(posedge clk); #1;
    sample_i = 1'b0;
    @(posedge clk); #1;
    sample_i = 1'b1;
    @(posedge clk); #1;
    sample_i = 1'b0;
    nval = 0;
    gap  = 1'b0;
    gotm = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid_o) begin
        nval++;
        gotm = int'(mixed_o);
      end else if (nval == 0 && !busy_o) begin
        gap = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("ovl_valids", nval, 1);
    check("ovl_busy_gap", gap, 0);
    check("ovl_mixed", gotm, em);

    // Strobe in the final (saturate) cycle: ignored
    drive();
    sample_i = 1'b1;
    model_mix(em, ep);
    @(posedge clk); #1;
    sample_i = 1'b0;
    repeat (NCH) @(posedge clk);
    #1;
    sample_i = 1'b1;
    @(posedge clk); #1;
    sample_i = 1'b0;
    check("satstb_valid", valid_o, 1);
    check("satstb_mixed", mixed_o, em);
    nval = 0;
    gap  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
      if (busy_o) gap = 1'b1;
    end
    check("satstb_novalid", nval, 0);
    check("satstb_nobusy", gap, 0);

    // Back-to-back: the strobe in the valid cycle starts a normal mix
    run_mix(gm, gp, em, ep);
    check("b2b_first", gm, em);
    run_mix(gm, gp, em, ep);
    check("b2b_second", gm, em);

    // Reset while the third channel is being accumulated
    for (int i = 0; i < NCH; i++) begin
      cur_ch[i] = 1000;
      cur_g[i]  = int'(GAIN_UNITY);
    end
    cur_en = '1;
    drive();
    sample_i = 1'b1;
    @(posedge clk); #1;
    sample_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("mrst_busy", busy_o, 0);
    check("mrst_valid", valid_o, 0);
    check("mrst_mixed", mixed_o, 0);
    check("mrst_peak", peak_o, 0);
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (valid_o) nval++;
    end
    check("mrst_novalid", nval, 0);

    // First mix after reset with channels disabled: silent for any input
    cur_en = '0;
    for (int i = 0; i < NCH; i++) cur_ch[i] = int'($signed(W'($urandom)));
    run_mix(gm, gp, em, ep);
    check("postrst_mixed", gm, 0);
    check("postrst_model", gm, em);

    // Randomized mixes against the model
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NCH; i++) begin
        cur_ch[i] = int'($signed(W'($urandom)));
        cur_g[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 32));
      end
      cur_en = NCH'($urandom);
      run_mix(gm, gp, em, ep);
      check("rand_mixed", gm, em);
      check("rand_peak", gp, ep);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_jtcps_snd_mixn
`default_nettype wire
